// File: rtl/cache_write_buffer.sv
// Posted write buffer between a write-through cache and main memory: queues writes, drains them in order, serves fill reads.
// Define WB_FORWARD_EN to forward read hits from the buffer and let non-hit reads bypass queued writes.
module cache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic                       wr_ready,
  input  logic                       rd_req,
  input  logic [AW-1:0]              rd_addr,
  output logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] wb_count,
  output logic                       wb_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef WB_FORWARD_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_FWD, S_RESP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0] buf_addr_q [DEPTH];
  logic [DW-1:0] buf_data_q [DEPTH];
  logic          push, pop, rd_acc;

  assign wr_ready = (count_q != FULL);
  assign push     = wr_req && wr_ready;
  assign pop      = (state_q == S_WR) && mem_ack;
  assign rd_acc   = rd_req && rd_ready;
  assign wb_count = count_q;
  assign wb_empty = (count_q == '0);
  assign rd_valid = (state_q == S_RESP);
  assign rd_data  = rd_data_q;

`ifdef WB_FORWARD_EN
  logic          hit;
  logic [DW-1:0] hit_data;

  assign rd_ready = (state_q == S_IDLE);

  // Scan oldest to newest so the last match left standing is the newest entry.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (buf_addr_q[head_q + PW'(i)] == rd_addr)) begin
        hit      = 1'b1;
        hit_data = buf_data_q[head_q + PW'(i)];
      end
    end
  end
`else
  logic          rd_pend_q, rd_pend_d;
  logic [CW-1:0] drain_left_q, drain_left_d;

  // A held read blocks further reads; it waits only for the entries older than itself.
  assign rd_ready = (state_q == S_IDLE) && !rd_pend_q;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    head_d    = pop  ? head_q + PW'(1) : head_q;
    tail_d    = push ? tail_q + PW'(1) : tail_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
`ifndef WB_FORWARD_EN
    rd_pend_d    = rd_pend_q;
    drain_left_d = drain_left_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef WB_FORWARD_EN
        if (rd_acc) begin
          rd_addr_d = rd_addr;
          if (hit) begin
            rd_data_d = hit_data;
            state_d   = S_FWD;
          end else begin
            state_d   = S_RD;
          end
        end else if ((count_q != '0) || push) begin
          state_d = S_WR;
        end
`else
        if (rd_acc) begin
          rd_addr_d = rd_addr;
          if (count_q == '0) begin
            state_d = S_RD;
          end else begin
            rd_pend_d    = 1'b1;
            drain_left_d = count_q;
            state_d      = S_WR;
          end
        end else if (rd_pend_q) begin
          if (drain_left_q == '0) begin
            rd_pend_d = 1'b0;
            state_d   = S_RD;
          end else begin
            state_d   = S_WR;
          end
        end else if ((count_q != '0) || push) begin
          state_d = S_WR;
        end
`endif
      end
      S_WR: begin
        if (mem_ack) begin
          state_d = S_IDLE;
`ifndef WB_FORWARD_EN
          if (rd_pend_q) drain_left_d = drain_left_q - CW'(1);
`endif
        end
      end
      S_RD: begin
        if (mem_ack) begin
          rd_data_d = mem_rdata;
          state_d   = S_RESP;
        end
      end
`ifdef WB_FORWARD_EN
      S_FWD:   state_d = S_RESP;
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = buf_addr_q[head_q];
        mem_wdata = buf_data_q[head_q];
      end
      S_RD: begin
        mem_req   = 1'b1;
        mem_addr  = rd_addr_q;
      end
      default: ;
    endcase
  end

  // NOTE: entry storage has no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[tail_q] <= wr_addr;
      buf_data_q[tail_q] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
`ifndef WB_FORWARD_EN
      rd_pend_q    <= 1'b0;
      drain_left_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
`ifndef WB_FORWARD_EN
      rd_pend_q    <= rd_pend_d;
      drain_left_q <= drain_left_d;
`endif
    end
  end

endmodule
